// File: rtl/collision_hp_tracker.sv
// Player/bone collision detector with HP, invulnerability frames and game-over tracking.
// Optional macro HP_REGEN_EN adds slow HP regeneration while ALIVE.
module collision_hp_tracker #(
  parameter int unsigned MAX_HP       = 20,
  parameter int unsigned DAMAGE       = 4,
  parameter int unsigned INV_FRAMES   = 30,
  parameter int unsigned PLAYER_W     = 8,
  parameter int unsigned PLAYER_H     = 8,
  parameter int unsigned REGEN_FRAMES = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  output logic       player_collision,
  output logic [6:0] hp,
  output logic       invuln,
  output logic       game_over,
  output logic [7:0] hit_count
);

  localparam int unsigned InvW    = $clog2(INV_FRAMES + 1);
  localparam logic [InvW-1:0] InvLoad = InvW'(INV_FRAMES);
  localparam logic [6:0] HpMax  = 7'(MAX_HP);
  localparam logic [6:0] HpDmg  = 7'(DAMAGE);
  localparam logic [8:0] PlayW  = 9'(PLAYER_W);
  localparam logic [7:0] PlayH  = 8'(PLAYER_H);
  localparam logic [8:0] BoneW  = 9'd8;
  localparam logic [7:0] BoneH  = 8'd4;

  typedef enum logic [1:0] {StAlive, StInvuln, StDead} state_e;

  state_e          state_q;
  logic            overlap_q;
  logic [InvW-1:0] inv_cnt_q;

  // Widened operands so box right/bottom edges never wrap.
  logic [8:0] px9, bx9;
  logic [7:0] py8, by8;
  logic       overlap_d;

  assign px9 = {1'b0, player_x};
  assign bx9 = {1'b0, bullet_x};
  assign py8 = {1'b0, player_y};
  assign by8 = {1'b0, bullet_y};

  assign overlap_d = enable & bullet_active &
                     (px9 < bx9 + BoneW) & (bx9 < px9 + PlayW) &
                     (py8 < by8 + BoneH) & (by8 < py8 + PlayH);

  always_ff @(posedge CLOCK_50) begin
    if (reset) overlap_q <= 1'b0;
    else       overlap_q <= overlap_d;
  end

`ifdef HP_REGEN_EN
  localparam int unsigned RegenW = $clog2(REGEN_FRAMES + 1);
  localparam logic [RegenW-1:0] RegenLast = RegenW'(REGEN_FRAMES - 1);
  logic [RegenW-1:0] regen_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q          <= StAlive;
      hp               <= HpMax;
      inv_cnt_q        <= '0;
      hit_count        <= 8'd0;
      player_collision <= 1'b0;
      invuln           <= 1'b0;
      game_over        <= 1'b0;
`ifdef HP_REGEN_EN
      regen_q          <= '0;
`endif
    end else if (!enable) begin
      player_collision <= 1'b0;
    end else begin
      player_collision <= 1'b0;
      case (state_q)
        StAlive: begin
          if (overlap_q) begin
            player_collision <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`ifdef HP_REGEN_EN
            regen_q <= '0;
`endif
            if (hp <= HpDmg) begin
              hp        <= 7'd0;
              state_q   <= StDead;
              game_over <= 1'b1;
            end else begin
              hp        <= hp - HpDmg;
              inv_cnt_q <= InvLoad;
              state_q   <= StInvuln;
              invuln    <= 1'b1;
            end
          end
`ifdef HP_REGEN_EN
          else if (frame_tick) begin
            if (regen_q == RegenLast) begin
              regen_q <= '0;
              if (hp < HpMax) hp <= hp + 7'd1;
            end else begin
              regen_q <= regen_q + 1'b1;
            end
          end
`endif
        end
        StInvuln: begin
`ifdef HP_REGEN_EN
          regen_q <= '0;
`endif
          if (frame_tick) begin
            if (inv_cnt_q == InvW'(1)) begin
              inv_cnt_q <= '0;
              state_q   <= StAlive;
              invuln    <= 1'b0;
            end else begin
              inv_cnt_q <= inv_cnt_q - 1'b1;
            end
          end
        end
        StDead: begin
          hp <= 7'd0;
`ifdef HP_REGEN_EN
          regen_q <= '0;
`endif
        end
        default: begin
          state_q   <= StAlive;
          invuln    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_hp_tracker.sv
// Self-checking bench for collision_hp_tracker: directed plan steps plus randomized traffic
// against a per-cycle behavioural model.
module tb_collision_hp_tracker;

  localparam int MaxHp = 20;
  localparam int Dmg   = 4;
  localparam int InvF  = 30;
  localparam int Pw    = 8;
  localparam int Ph    = 8;
  localparam int Rf    = 4;

  logic       clk = 1'b0;
  logic       reset, enable, frame_tick, bullet_active;
  logic [7:0] player_x, bullet_x;
  logic [6:0] player_y, bullet_y;
  logic       player_collision, invuln, game_over;
  logic [6:0] hp;
  logic [7:0] hit_count;

  always #5 clk = ~clk;

  collision_hp_tracker #(
    .MAX_HP(MaxHp), .DAMAGE(Dmg), .INV_FRAMES(InvF),
    .PLAYER_W(Pw), .PLAYER_H(Ph), .REGEN_FRAMES(Rf)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .player_collision(player_collision), .hp(hp),
    .invuln(invuln), .game_over(game_over), .hit_count(hit_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 = alive, 1 = invulnerable, 2 = dead.
  int m_st, m_hp, m_inv, m_hits, m_regen;
  bit m_pulse, m_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit boxes_hit(input int px, input int py, input int bx, input int by);
    return (px < bx + 8) && (bx < px + Pw) && (py < by + 4) && (by < py + Ph);
  endfunction

  task automatic model_edge();
    bit nov;
    nov = !reset && enable && bullet_active &&
          boxes_hit(int'(player_x), int'(player_y), int'(bullet_x), int'(bullet_y));
    if (reset) begin
      m_st = 0; m_hp = MaxHp; m_inv = 0; m_hits = 0; m_pulse = 0; m_regen = 0;
    end else begin
      m_pulse = 0;
      if (enable) begin
        if (m_st == 0) begin
          if (m_ov) begin
            m_pulse = 1;
            m_hits  = (m_hits < 255) ? m_hits + 1 : 255;
            m_regen = 0;
            if (m_hp <= Dmg) begin m_hp = 0; m_st = 2; end
            else begin m_hp = m_hp - Dmg; m_inv = InvF; m_st = 1; end
          end
`ifdef HP_REGEN_EN
          else if (frame_tick) begin
            m_regen++;
            if (m_regen == Rf) begin
              m_regen = 0;
              if (m_hp < MaxHp) m_hp++;
            end
          end
`endif
        end else if (m_st == 1) begin
          m_regen = 0;
          if (frame_tick) begin
            m_inv--;
            if (m_inv == 0) m_st = 0;
          end
        end else begin
          m_regen = 0;
        end
      end
    end
    m_ov = nov;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("pulse", {31'd0, player_collision}, {31'd0, m_pulse});
    check("hp", {25'd0, hp}, m_hp);
    check("invuln", {31'd0, invuln}, (m_st == 1) ? 1 : 0);
    check("game_over", {31'd0, game_over}, (m_st == 2) ? 1 : 0);
    check("hit_count", {24'd0, hit_count}, m_hits);
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0; cyc();
  endtask

  task automatic put(input int px, input int py, input int bx, input int by, input bit act);
    player_x = 8'(px); player_y = 7'(py); bullet_x = 8'(bx); bullet_y = 7'(by);
    bullet_active = act;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; frame_tick = 1'b0;
    put(0, 0, 120, 100, 1'b0);
    m_st = 0; m_hp = MaxHp; m_inv = 0; m_hits = 0; m_pulse = 0; m_ov = 0; m_regen = 0;
    do_reset();
    check("rst_hp", {25'd0, hp}, 20);
    check("rst_go", {31'd0, game_over}, 0);
    check("rst_inv", {31'd0, invuln}, 0);
    check("rst_hits", {24'd0, hit_count}, 0);

    // First hit: pulse exactly two cycles after coordinates appear.
    put(40, 50, 40, 50, 1'b1);
    cyc();
    check("lat1_pulse", {31'd0, player_collision}, 0);
    cyc();
    check("lat2_pulse", {31'd0, player_collision}, 1);
    check("hit1_hp", {25'd0, hp}, 16);
    check("hit1_inv", {31'd0, invuln}, 1);
    check("hit1_hits", {24'd0, hit_count}, 1);

    // Held overlap through invulnerability, re-hit right after the 30th tick.
    repeat (29) tick();
    check("inv29_inv", {31'd0, invuln}, 1);
    check("inv29_hits", {24'd0, hit_count}, 1);
    tick();
    check("rehit_pulse", {31'd0, player_collision}, 1);
    check("rehit_hp", {25'd0, hp}, 12);
    check("rehit_hits", {24'd0, hit_count}, 2);

    // Edge cases.
    do_reset();
    put(32, 50, 24, 50, 1'b1); repeat (3) cyc();
    check("touch_hits", {24'd0, hit_count}, 0);
    put(32, 50, 25, 50, 1'b1); repeat (3) cyc();
    check("overlap1_hits", {24'd0, hit_count}, 1);
    do_reset();
    put(0, 50, 252, 50, 1'b1); repeat (3) cyc();
    check("wrap_hits", {24'd0, hit_count}, 0);

    // Five spaced hits to death.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      put(40, 50, 40, 50, 1'b1); cyc(); cyc();
      check("five_pulse", {31'd0, player_collision}, 1);
      check("five_hp", {25'd0, hp}, 32'(MaxHp - Dmg * k));
      put(40, 50, 120, 50, 1'b1);
      repeat (30) tick();
    end
    check("dead_go", {31'd0, game_over}, 1);
    put(40, 50, 40, 50, 1'b1); repeat (4) cyc();
    check("dead_hits", {24'd0, hit_count}, 5);
    check("dead_hp", {25'd0, hp}, 0);
    do_reset();
    check("revive_hp", {25'd0, hp}, 20);
    check("revive_go", {31'd0, game_over}, 0);

    // Enable freeze mid-invulnerability.
    put(40, 50, 40, 50, 1'b1); cyc(); cyc();
    put(40, 50, 120, 50, 1'b1);
    repeat (10) tick();
    enable = 1'b0;
    repeat (100) tick();
    check("frz_hp", {25'd0, hp}, 16);
    check("frz_inv", {31'd0, invuln}, 1);
    enable = 1'b1;
    repeat (19) tick();
    check("resume19_inv", {31'd0, invuln}, 1);
    tick();
    check("resume20_inv", {31'd0, invuln}, 0);
    put(40, 50, 40, 50, 1'b0); repeat (4) cyc();
    check("inactive_hits", {24'd0, hit_count}, 1);

`ifdef HP_REGEN_EN
    do_reset();
    put(40, 50, 40, 50, 1'b1); cyc(); cyc();
    put(40, 50, 120, 50, 1'b1);
    repeat (30) tick();
    repeat (4) tick();
    check("regen_hp17", {25'd0, hp}, 17);
    repeat (Rf * 10) tick();
    check("regen_cap", {25'd0, hp}, 20);
    do_reset();
    put(40, 50, 40, 50, 1'b1); cyc(); cyc();
    put(40, 50, 120, 50, 1'b1);
    repeat (30) tick();
    repeat (3) tick();
    put(40, 50, 40, 50, 1'b1); cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    check("regen_vs_hit_hp", {25'd0, hp}, 12);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int px, py;
      px = int'($urandom_range(0, 159));
      py = int'($urandom_range(0, 119));
      put(px, py, px + int'($urandom_range(0, 24)) - 12, py + int'($urandom_range(0, 16)) - 8,
          ($urandom % 8) != 0);
      enable     = ($urandom % 16) != 0;
      frame_tick = ($urandom % 3) == 0;
      reset      = ($urandom % 400) == 0;
      cyc();
    end
    reset = 1'b0; frame_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
